// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: two-entry skid buffer (head H, skid S)
// with valid/ready handshake, flush/req clearing to an all-zero NOP bubble.
module pipe_stage_reg #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NFIELDS = 7,
    parameter bit          PC_KEEP = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NFIELDS*WIDTH-1:0] in_data,
    input  logic [31:0]              in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NFIELDS*WIDTH-1:0] out_data,
    output logic [31:0]              out_pc,
    output logic [1:0]               out_count
);

    localparam int unsigned DW = NFIELDS * WIDTH;
    localparam int unsigned PW = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [DW-1:0]   h_data, h_data_n, s_data, s_data_n;
    logic [PW-1:0]   h_pc, h_pc_n, s_pc, s_pc_n;
    logic            acc_in, acc_out;

    // Ready depends only on registered occupancy and the clear inputs.
    assign in_ready  = (state != TWO) & ~req & ~flush;
    assign out_valid = (state != EMPTY);
    assign acc_in    = in_valid & in_ready;
    assign acc_out   = out_valid & out_ready;
    assign out_count = state;
    assign out_data  = out_valid ? h_data : '0;
    assign out_pc    = h_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            h_data <= '0;
            h_pc   <= '0;
            s_data <= '0;
            s_pc   <= '0;
        end else begin
            state  <= state_n;
            h_data <= h_data_n;
            h_pc   <= h_pc_n;
            s_data <= s_data_n;
            s_pc   <= s_pc_n;
        end
    end

    // Next state and storage; vacated registers are zeroed so they read as NOP.
    always_comb begin
        state_n  = state;
        h_data_n = h_data;
        h_pc_n   = h_pc;
        s_data_n = s_data;
        s_pc_n   = s_pc;
        if (req) begin
            state_n  = EMPTY;
            h_data_n = '0;
            h_pc_n   = '0;
            s_data_n = '0;
            s_pc_n   = '0;
        end else if (flush) begin
            state_n  = EMPTY;
            h_data_n = '0;
            h_pc_n   = PC_KEEP ? h_pc : '0;
            s_data_n = '0;
            s_pc_n   = '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc_in) begin
                        state_n  = ONE;
                        h_data_n = in_data;
                        h_pc_n   = in_pc;
                    end
                end
                ONE: begin
                    if (acc_in && acc_out) begin
                        h_data_n = in_data;
                        h_pc_n   = in_pc;
                    end else if (acc_in) begin
                        state_n  = TWO;
                        s_data_n = in_data;
                        s_pc_n   = in_pc;
                    end else if (acc_out) begin
                        state_n  = EMPTY;
                        h_data_n = '0;
                        h_pc_n   = '0;
                    end
                end
                TWO: begin
                    if (acc_out) begin
                        state_n  = ONE;
                        h_data_n = s_data;
                        h_pc_n   = s_pc;
                        s_data_n = '0;
                        s_pc_n   = '0;
                    end
                end
                default: begin
                    state_n  = EMPTY;
                    h_data_n = '0;
                    h_pc_n   = '0;
                    s_data_n = '0;
                    s_pc_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: queue-based stage model, directed cases
// plus randomized traffic; a second instance covers the PC_KEEP=0 bubble.
module tb_pipe_stage_reg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned NFIELDS = 7;
    localparam int unsigned DW      = WIDTH * NFIELDS;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [31:0]   pc;
    } ent_t;

    logic          clk, rst, req, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [31:0]   in_pc;
    logic          in_ready, out_valid, in_ready0, out_valid0;
    logic [DW-1:0] out_data, out_data0;
    logic [31:0]   out_pc, out_pc0;
    logic [1:0]    out_count, out_count0;

    int total = 0;
    int bad   = 0;

    ent_t        stg[$];
    ent_t        sb[$];
    logic [31:0] bub;

    pipe_stage_reg #(.WIDTH(WIDTH), .NFIELDS(NFIELDS), .PC_KEEP(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pc(out_pc), .out_count(out_count)
    );

    pipe_stage_reg #(.WIDTH(WIDTH), .NFIELDS(NFIELDS), .PC_KEEP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_pc(in_pc),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_pc(out_pc0), .out_count(out_count0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < int'(NFIELDS); i++) d[i*WIDTH +: WIDTH] = $urandom;
        return d;
    endfunction

    // Monitor: every downstream handshake must deliver the oldest accepted entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            ent_t e;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got pc %0h expected no output at %0t", out_pc, $time);
            end else begin
                e = sb.pop_front();
                chk("mon_data", out_data, e.d);
                chk("mon_pc", DW'(out_pc), DW'(e.pc));
            end
        end
    end

    task automatic check_outputs();
        int n;
        n = stg.size();
        chk("out_count", DW'(out_count), DW'(n));
        chk("out_valid", DW'(out_valid), DW'(n != 0));
        chk("out_data", out_data, (n != 0) ? stg[0].d : '0);
        chk("out_pc", DW'(out_pc), DW'((n != 0) ? stg[0].pc : bub));
        chk("out_pc_nokeep", DW'(out_pc0), DW'((n != 0) ? stg[0].pc : 32'h0));
    endtask

    // One clock cycle of stimulus followed by the model update for that edge.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic rq, output logic took);
        logic exp_rdy, a_in, a_out;
        in_valid = iv; in_data = d; in_pc = pc; out_ready = ordy; flush = fl; req = rq;
        #1;
        exp_rdy = (stg.size() != 2) && !fl && !rq;
        chk("in_ready", DW'(in_ready), DW'(exp_rdy));
        a_in  = iv && exp_rdy;
        a_out = ordy && (stg.size() != 0);
        took  = a_in;
        @(posedge clk);
        #1;
        if (rq) begin
            stg.delete(); sb.delete(); bub = 32'h0;
        end else if (fl) begin
            bub = (stg.size() != 0) ? stg[0].pc : bub;
            stg.delete(); sb.delete();
        end else begin
            if (a_out) void'(stg.pop_front());
            if (a_in) begin
                stg.push_back('{d: d, pc: pc});
                sb.push_back('{d: d, pc: pc});
            end
            if (a_out && stg.size() == 0) bub = 32'h0;
        end
        check_outputs();
    endtask

    task automatic idle(input logic ordy);
        logic t;
        step(1'b0, '0, 32'h0, ordy, 1'b0, 1'b0, t);
    endtask

    initial begin
        logic        t;
        logic [31:0] pcs [3];
        int          k;
        pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008;
        rst = 1'b1; req = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_pc = '0; bub = 32'h0;
        #3;
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        check_outputs();
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Streaming at full throughput, then drain to a NOP bubble
        for (int i = 0; i < 3; i++) step(1'b1, rand_data(), pcs[i], 1'b1, 1'b0, 1'b0, t);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: third entry is held upstream until space frees up
        for (int i = 0; i < 3; i++) step(1'b1, rand_data(), pcs[i], 1'b0, 1'b0, 1'b0, t);
        begin
            logic [DW-1:0] d3;
            d3 = rand_data();
            t = 1'b0;
            k = 0;
            while (!t && k < 8) begin
                step(1'b1, d3, 32'h3008, 1'b1, 1'b0, 1'b0, t);
                k++;
            end
            chk("bp_accept_bound", DW'(t), DW'(1));
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Flush with two entries: bubble keeps head PC on dut, zero on dut0
        step(1'b1, rand_data(), 32'h3010, 1'b0, 1'b0, 1'b0, t);
        step(1'b1, rand_data(), 32'h3014, 1'b0, 1'b0, 1'b0, t);
        step(1'b0, '0, 32'h0, 1'b0, 1'b1, 1'b0, t);
        chk("flush_keep_pc", DW'(out_pc), DW'(32'h3010));
        chk("flush_nokeep_pc", DW'(out_pc0), DW'(32'h0));
        idle(1'b1);

        // req + flush together with a pending upstream entry
        step(1'b1, rand_data(), 32'h3018, 1'b0, 1'b0, 1'b0, t);
        step(1'b1, rand_data(), 32'h3020, 1'b0, 1'b1, 1'b1, t);
        chk("req_not_taken", DW'(t), DW'(0));
        chk("req_pc", DW'(out_pc), DW'(32'h0));
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset between edges with two entries held
        step(1'b1, rand_data(), 32'h3030, 1'b0, 1'b0, 1'b0, t);
        step(1'b1, rand_data(), 32'h3034, 1'b0, 1'b0, 1'b0, t);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; req = 1'b0;
        #2 rst = 1'b1;
        #1;
        stg.delete(); sb.delete(); bub = 32'h0;
        chk("arst_in_ready", DW'(in_ready), DW'(1));
        check_outputs();
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic with occasional flush and req
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom % 3 != 0), rand_data(), 32'h4000 + 32'(i * 4),
                 1'($urandom % 4 != 0), 1'($urandom % 16 == 0), 1'($urandom % 32 == 0), t);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("sb_drained", DW'(sb.size()), DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register: the generic successor to the fixed inter-stage registers of the MIPS pipeline (F/D, D/E, E/M, M/W). It carries NFIELDS packed data fields plus a PC through a two-entry skid buffer with a valid/ready handshake. Stalls propagate without combinational ready chains. Branch flush and exception request (Req) clear the stage to a NOP bubble. It sits between any two pipeline stages and replaces the per-stage hand-written registers.

## Interface
- WIDTH, 32, width of one data field
- NFIELDS, 7, number of packed data fields (IR, ALUO, DMRD, ...); field k occupies bits [k*WIDTH +: WIDTH]
- PC_KEEP, 1, when 1 a flush bubble retains the PC of the flushed head entry; when 0 the bubble PC is 0
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  1  exception request; synchronous clear of the whole stage, highest priority after rst
- flush  input  1  branch/pipeline flush; synchronous clear of the whole stage
- in_valid  input  1  upstream entry present
- in_ready  output  1  stage can accept; equals (count != 2) & ~req & ~flush
- in_data  input  NFIELDS*WIDTH  upstream fields
- in_pc  input  32  upstream PC
- out_valid  output  1  head entry valid; equals (count != 0)
- out_ready  input  1  downstream accepts head
- out_data  output  NFIELDS*WIDTH  head entry fields; all-zero (NOP) when out_valid=0
- out_pc  output  32  head entry PC, or bubble PC as defined below
- out_count  output  2  occupancy: 0, 1 or 2

## Operation
- Storage: head register H (data+PC), skid register S (data+PC), state EMPTY/ONE/TWO (out_count 0/1/2).
- Handshakes: acc_in = in_valid & in_ready; acc_out = out_valid & out_ready.
- EMPTY: acc_in -> ONE, H<=in.
- ONE: acc_in&acc_out -> ONE, H<=in. acc_in only -> TWO, S<=in. acc_out only -> EMPTY, H data<=0, H PC<=0.
- TWO: in_ready=0. acc_out -> ONE, H<=S, S<=0. Otherwise hold.
- Vacated registers are always zeroed, so IR=0 (sll $0,$0,0) is a NOP bubble.
- flush (req=0): next state EMPTY. H data and S are zeroed. H PC <= (PC_KEEP ? current H PC : 0), so a bubble keeps its PC for EPC/BD tracking. Any in_valid in the same cycle is not accepted, because in_ready is low.
- req: next state EMPTY. H and S are fully zeroed, including PC. req overrides flush when both are asserted.
- When out_valid=0, out_pc still shows H PC (the retained bubble PC or 0). out_data is 0.
- Ordering: entries leave in arrival order. No entry is duplicated or dropped except by flush/req.

## Timing
- rst asserted (async, any time): immediately count=0, out_valid=0, in_ready=1, out_data=0, out_pc=0, S=0. rst held overrides all inputs.
- Latency: an entry accepted at edge N is visible on out_* after edge N, i.e. 1 cycle.
- Throughput: 1 entry/cycle while out_ready=1.
- in_ready depends only on registered count plus the req/flush inputs. There is no path from out_ready to in_ready.
- Backpressure: the first out_ready=0 cycle can still absorb one entry into S. in_ready drops the cycle after count reaches 2. It rises the cycle after an acc_out in TWO.
- flush/req take effect at the next edge. out_count=0 and out_valid=0 in the following cycle. A head handshake in the flush cycle (acc_out) still completes for downstream.
- Simultaneous acc_in and acc_out in TWO cannot occur, because in_ready=0.

## Test plan
- Reset mid-stream: load two entries (count=2), assert rst asynchronously between edges -> out_valid=0, out_count=0, out_data=0, out_pc=0 immediately, before the next edge.
- Streaming: out_ready=1, push PCs 0x3000, 0x3004, 0x3008 on consecutive cycles -> same PCs on out_pc one cycle later each, out_count=1 throughout.
- Backpressure: hold out_ready=0, push 0x3000, 0x3004, 0x3008 -> in_ready low after second accept, 0x3008 held upstream. Release -> outputs 0x3000, 0x3004, 0x3008 in order, count 2->2->1->... with no loss.
- Flush with PC_KEEP=1: head PC 0x3010, count=2, flush=1 -> next cycle count=0, out_data=0, out_pc=0x3010. Same with PC_KEEP=0 -> out_pc=0.
- req+flush together with in_valid=1 (PC 0x3020) -> in_ready=0 that cycle, next cycle count=0, out_pc=0, and 0x3020 never appears at the output.
- Vacate: single entry drained with no new input -> out_valid=0, out_data all-zero (IR NOP), out_pc=0.
